// File: rtl/iterative_muldiv.sv
// Iterative multiply / divide unit with MADD/MSUB accumulate.
// Resolves UNROLL quotient or product bits per clock on operand magnitudes.
module iterative_muldiv #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             hold_result,
   input  logic [3:0]       muldiv_op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             wait_result,
   output logic             busy
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic                 r_div, r_madd, r_msub, r_neg_p, r_neg_r;
   logic [WIDTH-1:0]     r_h, r_l, r_d;
   logic [2*WIDTH-1:0]   r_acc;

   logic                 w_valid, w_is_div, w_signed, w_dbz, w_start;
   logic                 w_rs_neg, w_rt_neg;
   logic [WIDTH-1:0]     w_rs_mag, w_rt_mag;
   logic [WIDTH-1:0]     w_sh, w_sl;
   logic [WIDTH:0]       w_ss;
   logic [2*WIDTH-1:0]   w_prod, w_res;

   assign w_valid  = (muldiv_op >= 4'd1) && (muldiv_op <= 4'd8);
   assign w_is_div = (muldiv_op == 4'd3) || (muldiv_op == 4'd4);
   assign w_signed = w_valid && muldiv_op[0];
   assign w_rs_neg = w_signed && rs[WIDTH-1];
   assign w_rt_neg = w_signed && rt[WIDTH-1];
   assign w_rs_mag = w_rs_neg ? -rs : rs;
   assign w_rt_mag = w_rt_neg ? -rt : rt;
   assign w_dbz    = w_is_div && (rt == '0);
   assign w_start  = (r_state == S_IDLE) && w_valid && !clear;
   assign busy     = (r_state == S_RUN);

   // Multiply shifts the product right through {h,l}; divide shifts {rem,quot} left.
   always_comb begin
      w_sh = r_h;
      w_sl = r_l;
      w_ss = '0;
      for (int k = 0; k < UNROLL; k++) begin
         if (r_div) begin
            w_ss = {w_sh, w_sl[WIDTH-1]};
            w_sl = {w_sl[WIDTH-2:0], 1'b0};
            if (w_ss >= {1'b0, r_d}) begin
               w_ss    = w_ss - {1'b0, r_d};
               w_sl[0] = 1'b1;
            end
            w_sh = w_ss[WIDTH-1:0];
         end else begin
            w_ss = {1'b0, w_sh} + (w_sl[0] ? {1'b0, r_d} : '0);
            w_sl = {w_ss[0], w_sl[WIDTH-1:1]};
            w_sh = w_ss[WIDTH:1];
         end
      end
   end

   always_comb begin
      w_prod = {w_sh, w_sl};
      if (r_neg_p) w_prod = -w_prod;
      if (r_div) begin
         w_res = {r_neg_r ? -w_sh : w_sh, r_neg_p ? -w_sl : w_sl};
      end else if (r_madd) begin
         w_res = r_acc + w_prod;
      end else if (r_msub) begin
         w_res = r_acc - w_prod;
      end else begin
         w_res = w_prod;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wait_result = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               wait_result = 1'b1;
               w_state_nxt = w_dbz ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (clear) begin
               w_state_nxt = S_IDLE;
            end else begin
               wait_result = 1'b1;
               if (r_cnt == '0) w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (clear || !hold_result) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_madd  <= 1'b0;
         r_msub  <= 1'b0;
         r_neg_p <= 1'b0;
         r_neg_r <= 1'b0;
         r_h     <= '0;
         r_l     <= '0;
         r_d     <= '0;
         r_acc   <= '0;
         hi_out  <= '0;
         lo_out  <= '0;
      end else if (w_start) begin
         r_cnt   <= CW'(N - 1);
         r_div   <= w_is_div;
         r_madd  <= (muldiv_op == 4'd5) || (muldiv_op == 4'd6);
         r_msub  <= (muldiv_op == 4'd7) || (muldiv_op == 4'd8);
         r_neg_p <= w_rs_neg ^ w_rt_neg;
         r_neg_r <= w_rs_neg;
         r_h     <= '0;
         r_l     <= w_is_div ? w_rs_mag : w_rt_mag;
         r_d     <= w_is_div ? w_rt_mag : w_rs_mag;
         r_acc   <= {hi_in, lo_in};
         if (w_dbz) begin
            hi_out <= rs;
            lo_out <= '1;
         end
      end else if ((r_state == S_RUN) && !clear) begin
         r_h <= w_sh;
         r_l <= w_sl;
         if (r_cnt == '0) begin
            hi_out <= w_res[2*WIDTH-1:WIDTH];
            lo_out <= w_res[WIDTH-1:0];
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed bench for iterative_muldiv, UNROLL=1 and UNROLL=4 instances.
module tb_iterative_muldiv;

   logic        clk = 1'b0;
   logic        rst1, rst4;
   logic        clear, hold;
   logic [3:0]  op1, op4;
   logic [31:0] rs, rt, hi_in, lo_in;
   logic [31:0] hi1, lo1, hi4, lo4;
   logic        w1, w4, b1, b4;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc;
   logic [63:0] res;

   always #5 clk = ~clk;

   iterative_muldiv #(.WIDTH(32), .UNROLL(1)) u_dut1 (
      .clk(clk), .reset(rst1), .clear(clear), .hold_result(hold),
      .muldiv_op(op1), .rs(rs), .rt(rt), .hi_in(hi_in), .lo_in(lo_in),
      .hi_out(hi1), .lo_out(lo1), .wait_result(w1), .busy(b1)
   );

   iterative_muldiv #(.WIDTH(32), .UNROLL(4)) u_dut4 (
      .clk(clk), .reset(rst4), .clear(clear), .hold_result(hold),
      .muldiv_op(op4), .rs(rs), .rt(rt), .hi_in(hi_in), .lo_in(lo_in),
      .hi_out(hi4), .lo_out(lo4), .wait_result(w4), .busy(b4)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input bit u4, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         output int c, output logic [63:0] r);
      @(posedge clk); #1;
      rs = a; rt = b; hi_in = h; lo_in = l;
      if (u4) op4 = op; else op1 = op;
      #1;
      c = 0;
      while ((u4 ? w4 : w1) && c < 100) begin
         c++;
         @(posedge clk); #1;
         op1 = 4'd0; op4 = 4'd0;
         rs = ~a; rt = ~b; hi_in = ~h; lo_in = ~l;
         #1;
      end
      if (c >= 100) chk("timeout", 64'(c), 64'd0);
      r = u4 ? {hi4, lo4} : {hi1, lo1};
   endtask

   initial begin
      rst1 = 1'b1; rst4 = 1'b1; clear = 1'b0; hold = 1'b0;
      op1 = 4'd0; op4 = 4'd0;
      rs = '0; rt = '0; hi_in = '0; lo_in = '0;
      #1;
      chk("rst_out1", {hi1, lo1}, 64'd0);
      chk("rst_wait1", 64'(w1), 64'd0);
      chk("rst_busy1", 64'(b1), 64'd0);
      chk("rst_out4", {hi4, lo4}, 64'd0);
      repeat (2) @(posedge clk);
      #2; rst1 = 1'b0; rst4 = 1'b0;

      run_op(0, 4'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, cyc, res);
      chk("mult_cyc", 64'(cyc), 64'd33);
      chk("mult_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("done_busy", 64'(b1), 64'd0);

      run_op(0, 4'd4, 32'd100, 32'd7, 0, 0, cyc, res);
      chk("divu_cyc", 64'(cyc), 64'd33);
      chk("divu_res", res, {32'd2, 32'd14});

      run_op(0, 4'd3, -32'sd7, 32'd2, 0, 0, cyc, res);
      chk("div_neg", res, 64'hFFFF_FFFF_FFFF_FFFD);

      run_op(0, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, cyc, res);
      chk("div_ovf", res, {32'd0, 32'h8000_0000});

      run_op(0, 4'd4, 32'h1234, 32'd0, 0, 0, cyc, res);
      chk("dbz_cyc", 64'(cyc), 64'd1);
      chk("dbz_res", res, {32'h1234, 32'hFFFF_FFFF});

      run_op(0, 4'd6, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, cyc, res);
      chk("maddu", res, {32'd1, 32'd0});

      run_op(0, 4'd7, 32'd1, 32'd1, 32'd0, 32'd0, cyc, res);
      chk("msub", res, 64'hFFFF_FFFF_FFFF_FFFF);

      run_op(0, 4'd1, -32'sd3, 32'd5, 0, 0, cyc, res);
      chk("mult_neg", res, 64'hFFFF_FFFF_FFFF_FFF1);

      run_op(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, cyc, res);
      chk("multu_max", res, 64'hFFFF_FFFE_0000_0001);

      run_op(0, 4'd5, 32'd2, -32'sd3, 32'd0, 32'd10, cyc, res);
      chk("madd_neg", res, {32'd0, 32'd4});

      run_op(0, 4'd8, 32'd4, 32'd5, 32'd1, 32'd0, cyc, res);
      chk("msubu", res, {32'd0, 32'hFFFF_FFEC});

      @(posedge clk); #1;
      rs = 32'd9; rt = 32'd9; op1 = 4'd0; #1;
      chk("none_wait", 64'(w1), 64'd0);
      op1 = 4'd12; #1;
      chk("op12_wait", 64'(w1), 64'd0);
      repeat (3) @(posedge clk); #1;
      chk("none_out", {hi1, lo1}, {32'd0, 32'hFFFF_FFEC});
      op1 = 4'd0;

      @(posedge clk); #1;
      op1 = 4'd2; rs = 32'd3; rt = 32'd5; #1;
      chk("clr_start", 64'(w1), 64'd1);
      @(posedge clk); #1;
      op1 = 4'd0;
      repeat (9) @(posedge clk);
      #1; clear = 1'b1; #1;
      chk("clr_wait", 64'(w1), 64'd0);
      chk("clr_busy", 64'(b1), 64'd1);
      @(posedge clk); #1;
      clear = 1'b0; #1;
      chk("clr_idle", 64'(b1), 64'd0);
      chk("clr_out", {hi1, lo1}, {32'd0, 32'hFFFF_FFEC});
      repeat (3) @(posedge clk); #1;
      chk("clr_quiet", 64'(w1), 64'd0);

      hold = 1'b1;
      run_op(0, 4'd2, 32'd6, 32'd7, 0, 0, cyc, res);
      chk("hold_res", res, {32'd0, 32'd42});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #2;
         chk("hold_out", {hi1, lo1}, {32'd0, 32'd42});
         chk("hold_wait", 64'(w1), 64'd0);
      end
      hold = 1'b0;
      @(posedge clk); #1;
      run_op(0, 4'd4, 32'd50, 32'd5, 0, 0, cyc, res);
      chk("post_hold_cyc", 64'(cyc), 64'd33);
      chk("post_hold_res", res, {32'd0, 32'd10});

      @(posedge clk); #1;
      op1 = 4'd1; rs = 32'd7; rt = 32'd9;
      @(posedge clk); #1;
      op1 = 4'd0;
      repeat (5) @(posedge clk);
      #2; rst1 = 1'b1; #1;
      chk("arst_out", {hi1, lo1}, 64'd0);
      chk("arst_busy", 64'(b1), 64'd0);
      chk("arst_wait", 64'(w1), 64'd0);
      #3; rst1 = 1'b0;
      run_op(0, 4'd1, 32'd7, 32'd9, 0, 0, cyc, res);
      chk("arst_rerun_cyc", 64'(cyc), 64'd33);
      chk("arst_rerun", res, {32'd0, 32'd63});

      run_op(1, 4'd2, 32'd3, 32'd5, 0, 0, cyc, res);
      chk("u4_cyc", 64'(cyc), 64'd9);
      chk("u4_mul", res, {32'd0, 32'd15});
      run_op(1, 4'd4, 32'd100, 32'd7, 0, 0, cyc, res);
      chk("u4_div", res, {32'd2, 32'd14});
      run_op(1, 4'd1, -32'sd3, 32'd5, 0, 0, cyc, res);
      chk("u4_mult_neg", res, 64'hFFFF_FFFF_FFFF_FFF1);

      @(posedge clk); #1;
      op4 = 4'd2; rs = 32'd3; rt = 32'd5;
      @(posedge clk); #1;
      op4 = 4'd0;
      repeat (3) @(posedge clk);
      #2; rst4 = 1'b1; #1;
      chk("u4_arst_out", {hi4, lo4}, 64'd0);
      chk("u4_arst_busy", 64'(b4), 64'd0);
      chk("u4_arst_wait", 64'(w4), 64'd0);
      #3; rst4 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
